reg_write_queue: RTL and testbench

- Writer-side front end for the 32x32 register file's single write port.
- Collects retire results from two producers: the ALU path and the load path (loads complete late and are the older instruction in flight).
- Buffers them in a small in-order FIFO and drains exactly one write per cycle onto the register file's we/waddr/wdata port.
- Provides a lookup port so the decode stage can forward values still pending in the queue.

---
 rtl/reg_write_queue_pkg.sv | 15 +
 rtl/wq_lookup.sv | 35 +++
 rtl/reg_write_queue.sv | 143 ++++++++++++++
 tb/tb_reg_write_queue.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/reg_write_queue_pkg.sv
// Shared register-file constants used by the write queue and its lookup helper.
package reg_write_queue_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;
    localparam int QueueDepth = 4;

    localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b0;
    localparam logic                  WriteEnable  = 1'b1;
    localparam logic                  WriteDisable = 1'b0;
    localparam logic [RegBus-1:0]     ZeroWord     = 32'h0;
    localparam logic                  RstEnable    = 1'b1;

endpackage

// File: rtl/wq_lookup.sv
// Newest-match priority search over the pending write queue; also reused by decode forwarding.
module wq_lookup
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH  = QueueDepth,
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] i_addr [DEPTH],
    input  logic [DATA_W-1:0] i_data [DEPTH],
    input  logic [DEPTH-1:0]  i_valid,
    input  logic [PTR_W-1:0]  i_head,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    logic [PTR_W-1:0] w_slot;

    // Walk from the head (oldest) forward; a later match overrides, so the newest wins.
    always_comb begin
        o_hit  = 1'b0;
        o_data = DATA_W'(ZeroWord);
        w_slot = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_slot = i_head + PTR_W'(k);
            if (i_raddr != ADDR_W'(NOPRegAddr) && i_valid[w_slot] && i_addr[w_slot] == i_raddr) begin
                o_hit  = 1'b1;
                o_data = i_data[w_slot];
            end
        end
    end

endmodule

// File: rtl/reg_write_queue.sv
// In-order write queue feeding the register file's single write port.
// Optional macro WQ_INPUT_BYPASS_EN lets lookup also see this cycle's producer inputs.
module reg_write_queue
    import reg_write_queue_pkg::*;
#(
    parameter int DEPTH  = QueueDepth,
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_waddr,
    input  logic [DATA_W-1:0]          alu_wdata,
    input  logic                       mem_valid,
    input  logic [ADDR_W-1:0]          mem_waddr,
    input  logic [DATA_W-1:0]          mem_wdata,
    output logic                       stall_req,
    output logic                       we,
    output logic [ADDR_W-1:0]          waddr,
    output logic [DATA_W-1:0]          wdata,
    input  logic [ADDR_W-1:0]          lookup_raddr,
    output logic                       lookup_hit,
    output logic [DATA_W-1:0]          lookup_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic              w_deq;
    logic [CNT_W-1:0]  w_free;
    logic              w_memOk;
    logic              w_aluOk;
    logic              w_memAcc;
    logic              w_aluAcc;
    logic [PTR_W-1:0]  w_aluSlot;
    logic [PTR_W-1:0]  w_off;
    logic [DEPTH-1:0]  w_valid;
    logic              w_qHit;
    logic [DATA_W-1:0] w_qData;

    // Free slots are counted after this cycle's dequeue; the load is older so it claims a slot first.
    assign w_deq     = (r_count != '0);
    assign w_free    = CNT_W'(DEPTH) - r_count + CNT_W'(w_deq);
    assign w_memOk   = mem_valid && (mem_waddr != ADDR_W'(NOPRegAddr));
    assign w_aluOk   = alu_valid && (alu_waddr != ADDR_W'(NOPRegAddr));
    assign w_memAcc  = w_memOk && (w_free != '0);
    assign w_aluAcc  = w_aluOk && (w_free > CNT_W'(w_memAcc));
    assign w_aluSlot = r_wrPtr + PTR_W'(w_memAcc);

    assign stall_req = (r_count > CNT_W'(DEPTH-2));
    assign count     = r_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_memAcc) begin
            r_addr[r_wrPtr] <= mem_waddr;
            r_data[r_wrPtr] <= mem_wdata;
        end
        if (w_aluAcc) begin
            r_addr[w_aluSlot] <= alu_waddr;
            r_data[w_aluSlot] <= alu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rdPtr    <= r_rdPtr + PTR_W'(w_deq);
            r_wrPtr    <= r_wrPtr + PTR_W'(w_memAcc) + PTR_W'(w_aluAcc);
            r_count    <= r_count + CNT_W'(w_memAcc) + CNT_W'(w_aluAcc) - CNT_W'(w_deq);
            if ((w_memOk && !w_memAcc) || (w_aluOk && !w_aluAcc))
                r_overflow <= 1'b1;
        end
    end

    // The head drives the port directly; a reset cycle must never commit a write.
    always_comb begin
        we    = WriteDisable;
        waddr = ADDR_W'(NOPRegAddr);
        wdata = DATA_W'(ZeroWord);
        if (w_deq && rst != RstEnable) begin
            we    = WriteEnable;
            waddr = r_addr[r_rdPtr];
            wdata = r_data[r_rdPtr];
        end
    end

    always_comb begin
        w_valid = '0;
        w_off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off      = PTR_W'(i) - r_rdPtr;
            w_valid[i] = (CNT_W'(w_off) < r_count);
        end
    end

    wq_lookup #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_lookup (
        .i_addr  (r_addr),
        .i_data  (r_data),
        .i_valid (w_valid),
        .i_head  (r_rdPtr),
        .i_raddr (lookup_raddr),
        .o_hit   (w_qHit),
        .o_data  (w_qData)
    );

`ifdef WQ_INPUT_BYPASS_EN
    // ALU is the youngest instruction, then the load, then anything already queued.
    always_comb begin
        lookup_hit  = w_qHit;
        lookup_data = w_qData;
        if (w_aluOk && alu_waddr == lookup_raddr) begin
            lookup_hit  = 1'b1;
            lookup_data = alu_wdata;
        end else if (w_memOk && mem_waddr == lookup_raddr) begin
            lookup_hit  = 1'b1;
            lookup_data = mem_wdata;
        end
    end
`else
    assign lookup_hit  = w_qHit;
    assign lookup_data = w_qData;
`endif

endmodule

// File: tb/tb_reg_write_queue.sv
// Scoreboard bench for reg_write_queue: a queue model predicts every port write and lookup.
module tb_reg_write_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_waddr, mem_waddr, lookup_raddr;
    logic [31:0] alu_wdata, mem_wdata;
    logic        stall_req, we, lookup_hit, overflow;
    logic [4:0]  waddr;
    logic [31:0] wdata, lookup_data;
    logic [2:0]  count;

    ent_t mq[$];
    logic expOvf;
    int   checks = 0;
    int   errors = 0;

    reg_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_waddr    (alu_waddr),
        .alu_wdata    (alu_wdata),
        .mem_valid    (mem_valid),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .stall_req    (stall_req),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .lookup_raddr (lookup_raddr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Drives one cycle, compares mid-cycle outputs to the model, then advances the model at the edge.
    task automatic applyStimulus(input logic r,
                                 input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                 input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic [4:0] la);
        logic        eHit;
        logic [31:0] eData;
        rst = r;
        mem_valid = mv; mem_waddr = ma; mem_wdata = md;
        alu_valid = av; alu_waddr = aa; alu_wdata = ad;
        lookup_raddr = la;
        #1;
        eHit = 1'b0;
        eData = 32'h0;
        if (la != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!eHit && mq[i].a == la) begin
                    eHit = 1'b1;
                    eData = mq[i].d;
                end
            end
`ifdef WQ_INPUT_BYPASS_EN
            if (mv && ma == la) begin
                eHit = 1'b1;
                eData = md;
            end
            if (av && aa == la) begin
                eHit = 1'b1;
                eData = ad;
            end
`endif
        end
        if (!r && mq.size() != 0) begin
            checkOutput("we", 32'(we), 32'd1);
            checkOutput("waddr", 32'(waddr), 32'(mq[0].a));
            checkOutput("wdata", wdata, mq[0].d);
        end else begin
            checkOutput("we", 32'(we), 32'd0);
            checkOutput("waddr", 32'(waddr), 32'd0);
            checkOutput("wdata", wdata, 32'd0);
        end
        checkOutput("count", 32'(count), 32'(mq.size()));
        checkOutput("stall_req", 32'(stall_req), 32'(mq.size() > DEPTH - 2));
        checkOutput("overflow", 32'(overflow), 32'(expOvf));
        checkOutput("lookup_hit", 32'(lookup_hit), 32'(eHit));
        checkOutput("lookup_data", lookup_data, eData);
        @(posedge clk);
        if (r) begin
            mq.delete();
            expOvf = 1'b0;
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (mv && ma != 5'd0) begin
                if (mq.size() < DEPTH) mq.push_back('{a: ma, d: md});
                else expOvf = 1'b1;
            end
            if (av && aa != 5'd0) begin
                if (mq.size() < DEPTH) mq.push_back('{a: aa, d: ad});
                else expOvf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4:0] la);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, la);
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 0; mem_waddr = 0; mem_wdata = 0;
        alu_valid = 0; alu_waddr = 0; alu_wdata = 0;
        lookup_raddr = 0;
        expOvf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        idle(2, 5'd5);

        applyStimulus(0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd4);
        idle(3, 5'd3);

        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF, 5'd0);
        idle(2, 5'd0);

        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd7, 32'hA, 5'd7);
        applyStimulus(0, 1, 5'd2, 32'h2, 1, 5'd7, 32'hB, 5'd7);
        idle(4, 5'd7);

        applyStimulus(0, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd6);
        applyStimulus(0, 1, 5'd8, 32'h88, 1, 5'd10, 32'hAA, 5'd10);
        applyStimulus(0, 1, 5'd11, 32'hBB, 1, 5'd12, 32'hCC, 5'd12);
        applyStimulus(0, 1, 5'd13, 32'hDD, 1, 5'd14, 32'hEE, 5'd14);
        idle(6, 5'd14);

        applyStimulus(0, 1, 5'd12, 32'h12, 1, 5'd13, 32'h13, 5'd13);
        applyStimulus(0, 1, 5'd14, 32'h14, 1, 5'd15, 32'h15, 5'd15);
        applyStimulus(1, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd15);
        idle(4, 5'd15);

        for (int i = 0; i < 60; i++) begin
            logic honor;
            logic mv, av;
            honor = ($urandom_range(0, 3) != 0);
            mv = ($urandom_range(0, 1) == 1) && !(honor && stall_req);
            av = ($urandom_range(0, 1) == 1) && !(honor && stall_req);
            applyStimulus(0, mv, 5'($urandom_range(0, 7)), $urandom,
                          av, 5'($urandom_range(0, 7)), $urandom,
                          5'($urandom_range(0, 7)));
        end
        idle(6, 5'd3);

        applyStimulus(0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 5'd9);
        applyStimulus(0, 1, 5'd9, 32'h77, 1, 5'd9, 32'h78, 5'd9);
        idle(4, 5'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
